instr_fetch: RTL and testbench

- Fetch stage of the WF8 core. Sits directly upstream of the control decoder.
- Owns the program counter and issues byte reads to instruction memory over a req/ack handshake.
- Latches each fetched byte into the instruction register (IR). Presents opcode and operand fields downstream under a valid/ready handshake.
- Accepts redirects (jump/branch target) from execute and discards any fetch already in flight.

---
 rtl/instr_fetch_if.sv | 35 +++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory read port, IR valid/ready output
// and the redirect input from execute. master = fetch unit, slave = its environment.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 8
);
    logic                mem_rd_req;
    logic [PC_WIDTH-1:0] mem_rd_addr;
    logic                mem_rd_ack;
    logic [7:0]          mem_rd_data;

    logic                ir_valid;
    logic                ir_ready;
    logic [4:0]          ir_opcode;
    logic [2:0]          ir_operand;
    logic [PC_WIDTH-1:0] ir_pc;

    logic                redirect_en;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_ack, mem_rd_data,
        output ir_valid, ir_opcode, ir_operand, ir_pc,
        input  ir_ready,
        input  redirect_en, redirect_pc
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_ack, mem_rd_data,
        input  ir_valid, ir_opcode, ir_operand, ir_pc,
        output ir_ready,
        output redirect_en, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// WF8 fetch stage: owns the PC, reads instruction bytes over req/ack and presents the IR.
// Define FETCH_PREFETCH_EN to add a 1-entry skid buffer that prefetches while the IR is held.
module instr_fetch #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, ir_pc, drain_addr;
    logic [7:0]          ir;
    logic                ir_valid;

    logic                req, hit, ready, redir, hold_req;
    logic [PC_WIDTH-1:0] addr;

    logic                skid_full;
    logic [7:0]          skid_q;
    logic [PC_WIDTH-1:0] skid_pc;

    assign ready = bus.ir_ready;
    assign redir = bus.redirect_en;
    // ack only counts against a request we actually issued
    assign hit   = req & bus.mem_rd_ack;

`ifdef FETCH_PREFETCH_EN
    assign hold_req = ~skid_full;

    always_ff @(posedge clk) begin
        if (rst || redir) begin
            skid_full <= 1'b0;
        end else if (state == HOLD) begin
            if (ready) begin
                skid_full <= 1'b0;
            end else if (hit) begin
                skid_full <= 1'b1;
                skid_q    <= bus.mem_rd_data;
                skid_pc   <= pc;
            end
        end
    end
`else
    assign hold_req  = 1'b0;
    assign skid_full = 1'b0;
    assign skid_q    = '0;
    assign skid_pc   = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; redirect outranks everything but reset
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                if (redir)    state_nxt = hit ? REQ : DRAIN;
                else if (hit) state_nxt = HOLD;
            end
            HOLD: begin
                if (redir)                          state_nxt = (req && !hit) ? DRAIN : REQ;
                else if (ready && !skid_full && !hit) state_nxt = REQ;
            end
            DRAIN: if (hit) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; DRAIN keeps the abandoned address on the bus until it is acked
    always_comb begin
        req  = 1'b0;
        addr = pc;
        unique case (state)
            REQ:   req = 1'b1;
            HOLD:  req = hold_req;
            DRAIN: begin
                req  = 1'b1;
                addr = drain_addr;
            end
            default: ;
        endcase
    end

    // PC / IR datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= 8'h00;
            ir_pc      <= RESET_PC;
            ir_valid   <= 1'b0;
            drain_addr <= RESET_PC;
        end else if (redir) begin
            pc       <= bus.redirect_pc;
            ir_valid <= 1'b0;
            if (req && !hit && state != DRAIN) drain_addr <= addr;
        end else begin
            unique case (state)
                REQ: begin
                    if (hit) begin
                        ir       <= bus.mem_rd_data;
                        ir_pc    <= pc;
                        pc       <= pc + PC_ONE;
                        ir_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        if (skid_full) begin
                            ir    <= skid_q;
                            ir_pc <= skid_pc;
                        end else if (hit) begin
                            ir    <= bus.mem_rd_data;
                            ir_pc <= pc;
                            pc    <= pc + PC_ONE;
                        end else begin
                            ir_valid <= 1'b0;
                        end
                    end else if (hit) begin
                        pc <= pc + PC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rd_req  = req;
    assign bus.mem_rd_addr = addr;
    assign bus.ir_valid    = ir_valid;
    assign bus.ir_opcode   = ir[7:3];
    assign bus.ir_operand  = ir[2:0];
    assign bus.ir_pc       = ir_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed plan steps, then random ready/wait/redirect traffic
// scored against an in-order program-stream model (expected next consumed pc).
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.PC_WIDTH(8)) ifc ();
    instr_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (.clk(clk), .rst(rst), .bus(ifc));

    logic [7:0] mem [256];
    int         vectors = 0, miscompares = 0, consumed = 0;
    int         wait_n = 0, mcnt = 0;
    logic [7:0] exp_pc;
    logic       p_req, p_ack;
    logic [7:0] p_addr, sv_pc;
    logic [4:0] sv_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: memory answers, scoreboard scores consumes, then req-stability is checked
    task automatic tick();
        logic ack_now;
        ack_now = ifc.mem_rd_req && (mcnt >= wait_n);
        ifc.mem_rd_ack  = ack_now;
        ifc.mem_rd_data = ack_now ? mem[ifc.mem_rd_addr] : 8'($urandom);
        if (ifc.ir_valid && ifc.ir_ready) begin
            chk("cons_pc", 32'(ifc.ir_pc), 32'(exp_pc));
            chk("cons_ir", 32'({ifc.ir_opcode, ifc.ir_operand}), 32'(mem[exp_pc]));
            exp_pc++;
            consumed++;
        end
        if (ifc.redirect_en) exp_pc = ifc.redirect_pc;
        p_req  = ifc.mem_rd_req;
        p_addr = ifc.mem_rd_addr;
        p_ack  = ack_now;
        mcnt   = (ack_now || !p_req) ? 0 : mcnt + 1;
        @(posedge clk); #1;
        if (p_req && !p_ack) begin
            chk("req_hold", 32'(ifc.mem_rd_req), 32'd1);
            chk("addr_hold", 32'(ifc.mem_rd_addr), 32'(p_addr));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'b00011010;
        exp_pc = 8'h00; p_req = 1'b0; p_ack = 1'b0; p_addr = 8'h00;

        // Reset with an eager memory acking every cycle
        rst = 1'b1; ifc.ir_ready = 1'b0; ifc.redirect_en = 1'b0; ifc.redirect_pc = 8'h00;
        ifc.mem_rd_ack = 1'b1; ifc.mem_rd_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_req", 32'(ifc.mem_rd_req), 32'd0);
            chk("rst_valid", 32'(ifc.ir_valid), 32'd0);
        end
        chk("rst_ir", 32'({ifc.ir_opcode, ifc.ir_operand}), 32'd0);
        chk("rst_irpc", 32'(ifc.ir_pc), 32'd0);
        rst = 1'b0; ifc.mem_rd_ack = 1'b0;
        chk("idle_req", 32'(ifc.mem_rd_req), 32'd0);
        tick();
        chk("first_req", 32'(ifc.mem_rd_req), 32'd1);
        chk("first_addr", 32'(ifc.mem_rd_addr), 32'h00);

        // Basic fetch
        ifc.ir_ready = 1'b1;
        tick();
        chk("bf_valid", 32'(ifc.ir_valid), 32'd1);
        chk("bf_opcode", 32'(ifc.ir_opcode), 32'b00011);
        chk("bf_operand", 32'(ifc.ir_operand), 32'b010);
        chk("bf_irpc", 32'(ifc.ir_pc), 32'h00);
        tick();
`ifndef FETCH_PREFETCH_EN
        chk("bf_next_req", 32'(ifc.mem_rd_req), 32'd1);
        chk("bf_next_addr", 32'(ifc.mem_rd_addr), 32'h01);
`endif

        // Backpressure
        ifc.ir_ready = 1'b0;
        tick();
        sv_pc = ifc.ir_pc; sv_op = ifc.ir_opcode;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_irpc", 32'(ifc.ir_pc), 32'(sv_pc));
            chk("bp_opcode", 32'(ifc.ir_opcode), 32'(sv_op));
            chk("bp_valid", 32'(ifc.ir_valid), 32'd1);
`ifndef FETCH_PREFETCH_EN
            chk("bp_noreq", 32'(ifc.mem_rd_req), 32'd0);
`endif
        end
        ifc.ir_ready = 1'b1;
        tick();
`ifndef FETCH_PREFETCH_EN
        chk("bp_req", 32'(ifc.mem_rd_req), 32'd1);
        chk("bp_addr", 32'(ifc.mem_rd_addr), 32'(sv_pc + 8'd1));

        // Wait states: three cycles without ack at a fixed address
        wait_n = 3;
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", 32'(ifc.mem_rd_req), 32'd1);
            chk("ws_addr", 32'(ifc.mem_rd_addr), 32'h02);
            chk("ws_valid", 32'(ifc.ir_valid), 32'd0);
            tick();
        end
        chk("ws_valid_ack", 32'(ifc.ir_valid), 32'd0);
        tick();
        chk("ws_valid_rise", 32'(ifc.ir_valid), 32'd1);
        chk("ws_irpc", 32'(ifc.ir_pc), 32'h02);
`endif

        // Redirect while the read of 0x05 is outstanding
        wait_n = 0;
        for (int i = 0; i < 40 && !(ifc.mem_rd_req && ifc.mem_rd_addr == 8'h05); i++) tick();
        chk("rd_found", 32'(ifc.mem_rd_req && ifc.mem_rd_addr == 8'h05), 32'd1);
        wait_n = 2;
        ifc.redirect_en = 1'b1; ifc.redirect_pc = 8'h40;
        tick();
        ifc.redirect_en = 1'b0;
        chk("rd_req", 32'(ifc.mem_rd_req), 32'd1);
        chk("rd_old_addr", 32'(ifc.mem_rd_addr), 32'h05);
        chk("rd_valid", 32'(ifc.ir_valid), 32'd0);
        tick();
        tick();
        chk("rd_new_req", 32'(ifc.mem_rd_req), 32'd1);
        chk("rd_new_addr", 32'(ifc.mem_rd_addr), 32'h40);
        wait_n = 0;
        tick();
        chk("rd_valid2", 32'(ifc.ir_valid), 32'd1);
        chk("rd_irpc", 32'(ifc.ir_pc), 32'h40);

        // PC wrap
        ifc.redirect_en = 1'b1; ifc.redirect_pc = 8'hFE;
        tick();
        ifc.redirect_en = 1'b0;
        for (int i = 0; i < 20 && !(ifc.ir_valid && ifc.ir_pc == 8'hFF); i++) tick();
        chk("wr_found", 32'(ifc.ir_valid && ifc.ir_pc == 8'hFF), 32'd1);
`ifdef FETCH_PREFETCH_EN
        for (int i = 0; i < 10; i++) begin
            chk("pf_valid", 32'(ifc.ir_valid), 32'd1);
            tick();
        end
`else
        tick();
        chk("wr_req", 32'(ifc.mem_rd_req), 32'd1);
        chk("wr_addr", 32'(ifc.mem_rd_addr), 32'h00);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ifc.ir_ready = ($urandom_range(0, 3) != 0);
            if (mcnt == 0) wait_n = $urandom_range(0, 2);
            ifc.redirect_en = ($urandom_range(0, 31) == 0);
            ifc.redirect_pc = 8'($urandom);
            tick();
        end
        ifc.redirect_en = 1'b0;
        chk("progress", 32'(consumed > 200), 32'd1);

        // Reset while a read is pending
        ifc.ir_ready = 1'b0; wait_n = 5;
        for (int i = 0; i < 10 && !ifc.mem_rd_req; i++) tick();
        rst = 1'b1; ifc.mem_rd_ack = 1'b0;
        @(posedge clk); #1;
        chk("rr_req", 32'(ifc.mem_rd_req), 32'd0);
        chk("rr_valid", 32'(ifc.ir_valid), 32'd0);
        chk("rr_irpc", 32'(ifc.ir_pc), 32'h00);
        rst = 1'b0; p_req = 1'b0; mcnt = 0; exp_pc = 8'h00; wait_n = 0;
        ifc.ir_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
